// File: rtl/coord_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coord_pkg
// Purpose  : Shared state encoding and default sizing for the coordinate list
//            builder.
// Revision : 1.0 - initial release
// ============================================================================
package coord_pkg;

    localparam int COORD_W_DEF    = 8;
    localparam int NUM_AXES_DEF   = 2;
    localparam int MAX_POINTS_DEF = 16;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Keeps the address bus at least one bit wide for a single-entry list.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : coord_pkg
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : rise_detect
// Purpose  : One-cycle pulse on a low-to-high transition of a level request.
// Revision : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic prev;
    logic armed;

    // armed only sets once the input has been seen low after reset, so a
    // level already high at reset release never counts as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= din;
            armed <= armed | ~din;
        end
    end

    assign pulse = din & ~prev & armed;

endmodule : rise_detect
`default_nettype wire

// File: rtl/coord_list_builder.sv
`default_nettype none
// ============================================================================
// Module   : coord_list_builder
// Purpose  : Collects distinct points into an external memory, one write per
//            accepted request, until the list is closed or cleared.
// Revision : 1.0 - initial release
// ============================================================================
module coord_list_builder
    import coord_pkg::*;
#(
    parameter int COORD_W    = COORD_W_DEF,
    parameter int NUM_AXES   = NUM_AXES_DEF,
    parameter int MAX_POINTS = MAX_POINTS_DEF,
    parameter int PW         = NUM_AXES * COORD_W,
    parameter int ADDR_W     = addr_width(MAX_POINTS),
    parameter int CNT_W      = $clog2(MAX_POINTS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PW-1:0]     coord_in,
    input  logic              enter_req,
    input  logic              finish_req,
    input  logic              clear,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PW-1:0]     mem_wdata,
    output logic              mem_wren,
    output logic [CNT_W-1:0]  point_count,
    output logic [PW-1:0]     last_point,
    output logic              full,
    output logic              reject,
    output logic              done
);

    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_POINTS);

    state_t            state,     state_n;
    logic [CNT_W-1:0]  count_q,   count_n;
    logic [PW-1:0]     last_q,    last_n;
    logic [PW-1:0]     cap_q,     cap_n;
    logic [ADDR_W-1:0] addr_q,    addr_n;
    logic              pending_q, pending_n;
    logic              reject_q,  reject_n;

    logic enter_ev;
    logic finish_ev;
    logic enter_ok;

    rise_detect u_enter_rd (
        .clk   (clk),
        .reset (reset),
        .din   (enter_req),
        .pulse (enter_ev)
    );

    rise_detect u_finish_rd (
        .clk   (clk),
        .reset (reset),
        .din   (finish_req),
        .pulse (finish_ev)
    );

    assign full     = (count_q == C_MAX_CNT);
    assign enter_ok = !full && ((count_q == '0) || (coord_in != last_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= COLLECT;
            count_q   <= '0;
            last_q    <= '0;
            cap_q     <= '0;
            addr_q    <= '0;
            pending_q <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state     <= state_n;
            count_q   <= count_n;
            last_q    <= last_n;
            cap_q     <= cap_n;
            addr_q    <= addr_n;
            pending_q <= pending_n;
            reject_q  <= reject_n;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count_q;
        last_n    = last_q;
        cap_n     = cap_q;
        addr_n    = addr_q;
        pending_n = pending_q;
        reject_n  = 1'b0;

        if (clear) begin
            // The strobe of a WRITE cycle still fires; only the count is lost.
            state_n   = COLLECT;
            count_n   = '0;
            last_n    = '0;
            pending_n = 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (enter_ev && enter_ok) begin
                        state_n   = WRITE;
                        cap_n     = coord_in;
                        addr_n    = count_q[ADDR_W-1:0];
                        pending_n = finish_ev;
                    end else begin
                        if (enter_ev) begin
                            reject_n = 1'b1;
                        end
                        if (finish_ev) begin
                            if (count_q != '0) begin
                                state_n = DONE;
                            end else begin
                                reject_n = 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    count_n   = count_q + CNT_W'(1);
                    last_n    = cap_q;
                    pending_n = 1'b0;
                    state_n   = (pending_q || finish_ev) ? DONE : COLLECT;
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = COLLECT;
                end
            endcase
        end
    end

    // Strobe decoded from state so an asynchronous reset removes it at once.
    assign mem_wren    = (state == WRITE);
    assign mem_addr    = addr_q;
    assign mem_wdata   = cap_q;
    assign point_count = count_q;
    assign last_point  = last_q;
    assign reject      = reject_q;
    assign done        = (state == DONE);

endmodule : coord_list_builder
`default_nettype wire

// File: tb/tb_coord_list_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_coord_list_builder
// Purpose  : Directed self-checking bench with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coord_list_builder;

    localparam int COORD_W    = 8;
    localparam int NUM_AXES   = 2;
    localparam int MAX_POINTS = 4;
    localparam int PW         = NUM_AXES * COORD_W;
    localparam int ADDR_W     = 2;
    localparam int CNT_W      = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [PW-1:0]     coord_in;
    logic              enter_req;
    logic              finish_req;
    logic              clear;
    logic [ADDR_W-1:0] mem_addr;
    logic [PW-1:0]     mem_wdata;
    logic              mem_wren;
    logic [CNT_W-1:0]  point_count;
    logic [PW-1:0]     last_point;
    logic              full;
    logic              reject;
    logic              done;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int rej_cnt  = 0;
    logic wren_prev = 1'b0;
    logic [ADDR_W+PW-1:0] sb[$];

    coord_list_builder #(
        .COORD_W    (COORD_W),
        .NUM_AXES   (NUM_AXES),
        .MAX_POINTS (MAX_POINTS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coord_in    (coord_in),
        .enter_req   (enter_req),
        .finish_req  (finish_req),
        .clear       (clear),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wren    (mem_wren),
        .point_count (point_count),
        .last_point  (last_point),
        .full        (full),
        .reject      (reject),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: pops the scoreboard on every strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (reject === 1'b1) rej_cnt++;
        if (mem_wren === 1'b1) begin
            wr_cnt++;
            check("wren_not_back_to_back", 32'(wren_prev), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                check("write_addr_data", 32'({mem_addr, mem_wdata}), 32'(sb.pop_front()));
            end
        end
        wren_prev = (mem_wren === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int addr, input logic [7:0] x, input logic [7:0] y);
        sb.push_back({ADDR_W'(addr), y, x});
    endtask

    task automatic enter_pt(input logic [7:0] x, input logic [7:0] y);
        coord_in  = {y, x};
        enter_req = 1'b1;
        tick(1);
        enter_req = 1'b0;
        tick(2);
    endtask

    task automatic pulse_finish();
        finish_req = 1'b1;
        tick(1);
        finish_req = 1'b0;
        tick(2);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
    endtask

    int r0;
    int w0;

    initial begin
        reset = 1'b1; coord_in = '0; enter_req = 1'b0; finish_req = 1'b0; clear = 1'b0;
        tick(3);
        check("rst_count", 32'(point_count), 32'd0);
        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_addr_data", 32'({mem_addr, mem_wdata}), 32'd0);
        check("rst_last", 32'(last_point), 32'd0);
        check("rst_flags", 32'({full, reject, done}), 32'd0);
        reset = 1'b0;
        tick(2);

        // Three distinct points
        push(0, 8'd1, 8'd2); enter_pt(8'd1, 8'd2);
        push(1, 8'd3, 8'd4); enter_pt(8'd3, 8'd4);
        push(2, 8'd5, 8'd6); enter_pt(8'd5, 8'd6);
        check("three_count", 32'(point_count), 32'd3);
        check("three_last", 32'(last_point), 32'h0605);
        check("three_sb_empty", 32'(sb.size()), 32'd0);
        do_clear();
        check("clear_count", 32'(point_count), 32'd0);
        check("clear_last", 32'(last_point), 32'd0);

        // Duplicate point rejected
        r0 = rej_cnt;
        push(0, 8'd7, 8'd7); enter_pt(8'd7, 8'd7);
        enter_pt(8'd7, 8'd7);
        check("dup_count", 32'(point_count), 32'd1);
        check("dup_reject", 32'(rej_cnt - r0), 32'd1);
        do_clear();

        // Overflow past MAX_POINTS
        r0 = rej_cnt; w0 = wr_cnt;
        for (int i = 0; i < 6; i++) begin
            if (i < MAX_POINTS) push(i, 8'(10 + i), 8'(20 + i));
            enter_pt(8'(10 + i), 8'(20 + i));
        end
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_count", 32'(point_count), 32'd4);
        check("ovf_reject", 32'(rej_cnt - r0), 32'd2);
        check("ovf_writes", 32'(wr_cnt - w0), 32'd4);
        do_clear();
        check("clear_full", 32'(full), 32'd0);

        // Simultaneous enter and finish
        push(0, 8'd9, 8'd9);
        coord_in = 16'h0909; enter_req = 1'b1; finish_req = 1'b1;
        tick(1);
        enter_req = 1'b0; finish_req = 1'b0;
        tick(1);
        check("simul_done", 32'(done), 32'd1);
        check("simul_count", 32'(point_count), 32'd1);
        r0 = rej_cnt; w0 = wr_cnt;
        enter_pt(8'd11, 8'd11);
        pulse_finish();
        check("done_ignore_reject", 32'(rej_cnt - r0), 32'd0);
        check("done_ignore_write", 32'(wr_cnt - w0), 32'd0);
        check("done_hold", 32'(done), 32'd1);
        do_clear();
        check("clear_done", 32'(done), 32'd0);
        check("clear_after_done_count", 32'(point_count), 32'd0);

        // Finish with an empty list, then restart from address 0
        r0 = rej_cnt;
        pulse_finish();
        check("empty_finish_reject", 32'(rej_cnt - r0), 32'd1);
        check("empty_finish_done", 32'(done), 32'd0);
        push(0, 8'd4, 8'd8); enter_pt(8'd4, 8'd8);
        pulse_finish();
        check("finish_done", 32'(done), 32'd1);
        do_clear();
        push(0, 8'd2, 8'd3); enter_pt(8'd2, 8'd3);
        check("restart_count", 32'(point_count), 32'd1);

        // Request level high across reset release
        w0 = wr_cnt;
        reset = 1'b1; enter_req = 1'b1; coord_in = 16'h3333;
        tick(2);
        reset = 1'b0;
        tick(3);
        check("held_enter_writes", 32'(wr_cnt - w0), 32'd0);
        check("held_enter_count", 32'(point_count), 32'd0);
        enter_req = 1'b0;
        tick(2);

        // Reset during the WRITE cycle
        coord_in = 16'h4444; enter_req = 1'b1;
        tick(1);
        check("write_cycle_wren", 32'(mem_wren), 32'd1);
        #1 reset = 1'b1;
        #1 check("async_drop_wren", 32'(mem_wren), 32'd0);
        check("async_count", 32'(point_count), 32'd0);
        enter_req = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);

        // Finish arriving during WRITE is held as pending
        push(0, 8'h55, 8'h66);
        coord_in = 16'h6655; enter_req = 1'b1;
        tick(1);
        finish_req = 1'b1;
        tick(1);
        enter_req = 1'b0; finish_req = 1'b0;
        tick(1);
        check("pending_done", 32'(done), 32'd1);
        check("pending_count", 32'(point_count), 32'd1);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_coord_list_builder
`default_nettype wire

// File: doc/coord_list_builder.md
COORD_LIST_BUILDER -- requirements
Module: coord_list_builder

Interface
REQ-001 SHALL have parameter COORD_W, default 8, meaning bits per axis.
REQ-002 SHALL have parameter NUM_AXES, default 2, meaning axes per point (2 = x/y).
REQ-003 SHALL have parameter MAX_POINTS, default 16, meaning list depth; ADDR_W = clog2(MAX_POINTS), CNT_W = clog2(MAX_POINTS+1).
REQ-004 SHALL have port clk  input  1  the single clock; all logic is in this domain.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port coord_in  input  NUM_AXES*COORD_W  candidate point; axis 0 in the LSBs.
REQ-007 SHALL have port enter_req  input  1  level request to store coord_in; acts on its rising edge.
REQ-008 SHALL have port finish_req  input  1  level request to close the list; acts on its rising edge.
REQ-009 SHALL have port clear  input  1  synchronous restart of collection.
REQ-010 SHALL have port mem_addr  output  ADDR_W  write address.
REQ-011 SHALL have port mem_wdata  output  NUM_AXES*COORD_W  write data.
REQ-012 SHALL have port mem_wren  output  1  one-cycle write strobe.
REQ-013 SHALL have port point_count  output  CNT_W  number of stored points.
REQ-014 SHALL have port last_point  output  NUM_AXES*COORD_W  most recently stored point, for display.
REQ-015 SHALL have port full  output  1  point_count == MAX_POINTS.
REQ-016 SHALL have port reject  output  1  one-cycle pulse when a request is refused.
REQ-017 SHALL have port done  output  1  list closed.

Function
REQ-018 SHALL detect rising edges of enter_req and finish_req (req & ~req_prev); a held level SHALL produce exactly one event.
REQ-019 SHALL use states COLLECT, WRITE, DONE.
REQ-020 In COLLECT, an enter edge with !full and coord_in != last_point (or point_count == 0) SHALL capture coord_in and go to WRITE.
REQ-021 In WRITE (one cycle after the edge), mem_wren SHALL be 1, mem_addr = point_count, mem_wdata = captured point; on the next cycle point_count increments, last_point updates, and the state returns to COLLECT (or DONE if a finish is pending).
REQ-022 An enter edge when full, or with coord_in equal to last_point while point_count > 0, SHALL pulse reject for one cycle and write nothing.
REQ-023 A finish edge in COLLECT with point_count > 0 SHALL enter DONE on the next cycle; with point_count == 0 it SHALL pulse reject and remain in COLLECT.
REQ-024 For simultaneous enter and finish edges, enter SHALL be serviced first and finish latched as pending; DONE follows WRITE directly.
REQ-025 A finish edge arriving while in WRITE SHALL be latched as pending.
REQ-026 In DONE, done = 1, enter and finish edges SHALL be ignored without reject, and mem_wren = 0.
REQ-027 clear SHALL take priority over all events in any state: next cycle COLLECT, point_count 0, last_point 0, done 0, pending cleared. Memory contents are not erased; a write in progress completes its single-cycle strobe.
REQ-028 mem_wren SHALL never be high for two consecutive cycles, and mem_addr SHALL never be >= MAX_POINTS while mem_wren is high.

Reset
REQ-029 On reset assertion, asynchronously: state COLLECT, point_count 0, last_point 0, mem_wren 0, mem_addr 0, mem_wdata 0, full 0, reject 0, done 0, edge registers 0, pending 0.
REQ-030 Reset mid-WRITE SHALL drop mem_wren immediately; that point is not counted.
REQ-031 A request level already high at reset release SHALL NOT generate an event (edge register held at 0 during reset, requiring a low-to-high transition).

Structure
REQ-032 Package coord_pkg SHALL hold the state enum and default COORD_W/NUM_AXES/MAX_POINTS constants.
REQ-033 Sub-module rise_detect (1-bit registered rising-edge pulse, clk/reset) SHALL be instantiated once per request input.

Verification
REQ-034 Three enters with points (1,2),(3,4),(5,6) -> writes at addr 0,1,2 with matching data, point_count 3, last_point (5,6).
REQ-035 Enter (7,7) twice -> one write, second enter pulses reject, point_count 1.
REQ-036 MAX_POINTS=4, six distinct enters -> four writes, full=1, two reject pulses, no write at addr >= 4.
REQ-037 Enter (9,9) and finish rising in the same cycle -> write at addr 0 followed by done=1, point_count 1.
REQ-038 Finish with zero points -> reject pulse, done stays 0; then clear after DONE -> point_count 0, next enter writes at addr 0.
REQ-039 enter_req held high across reset release -> no write; reset asserted in the WRITE cycle -> mem_wren falls asynchronously, point_count 0.
